shift_reg_ctrl: RTL and testbench
=================================

Name: shift_reg_ctrl

Overview:
Sequencing controller for the 10-bit display shift register driven from the DE-board keys and switches.
- Converts a raw push-button into clean single shift pulses.
- Provides a free-running auto-shift mode at a fixed prescaled rate.
- Performs a flush that shifts zeros through the whole register.
- Keeps a BCD count of shifts for the HEX1/HEX0 display decoders.

It sits between the board I/O (KEY/SW) and the shift-register datapath.

Parameters:
WIDTH, 10, shift-register length; number of zero shifts performed by a flush
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level (10 ms at 50 MHz)
AUTO_DIV, 25000000, clock cycles between auto-mode shifts (0.5 s at 50 MHz)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
RESET  in  1  asynchronous, active-high reset
step_n  in  1  raw step button, active-low, asynchronous to CLOCK_50
run  in  1  raw auto-mode switch level; 1 = auto shifting
din  in  1  raw serial data switch; bit shifted in on manual/auto shifts
flush  in  1  raw flush request; acted on at rising edge
shift_en  out  1  one-cycle shift strobe to the shift register
shift_din  out  1  serial bit presented with shift_en
cnt_tens  out  4  BCD tens of shift count
cnt_ones  out  4  BCD ones of shift count
state  out  2  FSM state: 0 IDLE, 1 AUTO, 2 FLUSH
busy  out  1  high while in FLUSH

Behaviour:
- Reset (async, active-high): state=IDLE; shift_en=0; shift_din=0; cnt=00; busy=0; prescaler=0; flush counter=0; debounced step level=1 (released); all synchronizer flops=0 except step chain=1.
- Synchronization: step_n, run, din and flush each pass a 2-FF synchronizer; all logic uses the synchronized versions.
- Debounce on step:
  - Accepted level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any differing sample restarts the count.
  - A falling edge of the accepted level produces a 1-cycle step_evt.
- Flush detection: flush_evt is the rising edge of synchronized flush.
- All outputs are registered. shift_en asserts the cycle after the triggering event, always for exactly 1 cycle except in FLUSH.
- State machine:
  - IDLE:
    - flush_evt → FLUSH; cnt cleared to 00 on entry.
    - else run_s=1 → AUTO, prescaler=0.
    - else step_evt → shift_en=1, shift_din=din_s, cnt+1.
  - AUTO:
    - Prescaler counts 0..AUTO_DIV-1. On reaching AUTO_DIV-1: shift_en=1, shift_din=din_s, cnt+1, prescaler wraps to 0.
    - step_evt is ignored.
    - flush_evt → FLUSH (prescaler discarded, takes priority).
    - else run_s=0 → IDLE, prescaler=0.
  - FLUSH:
    - shift_en=1 and shift_din=0 for exactly WIDTH consecutive cycles, then IDLE. busy=1 throughout.
    - cnt is not incremented during FLUSH.
    - run, step_evt and flush_evt are ignored.
- Counter: 2-digit BCD, 00..99. 99 + 1 wraps to 00. ones=9 carries into tens.
- Simultaneous events in IDLE: flush_evt beats run_s, which beats step_evt; a losing step_evt is dropped, not queued.
- First auto shift occurs AUTO_DIV cycles after entering AUTO.
- RESET mid-FLUSH or mid-AUTO: immediate return to reset values. A partial flush is not resumed.

Decomposition:
- Package shift_ctrl_pkg:
  - state encoding constants (ST_IDLE=2'd0, ST_AUTO=2'd1, ST_FLUSH=2'd2)
  - WIDTH default
  - BCD digit width (4)
- Sub-module key_debounce (2-FF sync, stability counter, falling-edge pulse output).
  - Used once for step.
  - Reusable for other KEY inputs.

Test Plan:
Run with DEBOUNCE_CYCLES=4, AUTO_DIV=8, WIDTH=10.
1. Reset: assert RESET mid-clock, no clock edge → all outputs 0, state=0, cnt=00 immediately.
2. Manual step: din=1; step_n low for 20 cycles, then high → exactly one shift_en pulse with shift_din=1; cnt=01. A 2-cycle glitch on step_n → no pulse.
3. Auto: run=1 for 40 cycles after sync → state=1; shift_en every 8 cycles, 4-5 pulses; cnt advances accordingly. run=0 → state=0 and pulses stop.
4. Flush: with cnt=05, raise flush → state=2, busy=1, shift_en high 10 consecutive cycles with shift_din=0, cnt=00, then state=0.
5. Wrap/priority:
   - 100 manual steps → cnt 99 then 00.
   - flush edge and step_evt in the same cycle → FLUSH entered and no extra shift counted.
   - RESET during FLUSH cycle 5 → state=0, shift_en=0.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the display shift-register controller.
//   state_t  : controller FSM state (IDLE / AUTO / FLUSH)
//   bcd2_t   : two-digit BCD shift count
//   bcd2_inc : modulo-100 BCD increment
package shift_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 10;
  localparam int unsigned BCD_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AUTO  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  // 99 + 1 wraps to 00; a ones digit of 9 carries into tens.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = '0;
      r.tens = (v.tens == 4'd9) ? '0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_reg_ctrl_if.sv
// Board-side signal bundle of the shift-register controller.
//   step_n, run, din, flush          : raw KEY/SW levels into the controller
//   shift_en, shift_din              : shift strobe and serial bit to the datapath
//   cnt_tens, cnt_ones               : BCD shift count for HEX1/HEX0
//   state, busy                      : FSM state and flush-in-progress flag
// master = board / stimulus side, slave = controller.
interface shift_reg_ctrl_if;
  import shift_ctrl_pkg::*;

  logic       step_n;
  logic       run;
  logic       din;
  logic       flush;
  logic       shift_en;
  logic       shift_din;
  bcd_t       cnt_tens;
  bcd_t       cnt_ones;
  logic [1:0] state;
  logic       busy;

  modport master (
    output step_n, run, din, flush,
    input  shift_en, shift_din, cnt_tens, cnt_ones, state, busy
  );

  modport slave (
    input  step_n, run, din, flush,
    output shift_en, shift_din, cnt_tens, cnt_ones, state, busy
  );

endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter and
// falling-edge pulse of the accepted level.
//   clk, rst  : clock, asynchronous active-high reset
//   key_n_i   : raw active-low key, asynchronous to clk
//   level_o   : accepted (debounced) level
//   fall_o    : one-cycle pulse when the accepted level goes 1 -> 0
module key_debounce #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter bit          RESET_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q;

  // Counts consecutive synchronized samples that disagree with the accepted
  // level; since the input is binary this equals "identical samples".
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {2{RESET_LEVEL}};
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= level_q & ~level_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Sequencing controller for the 10-bit display shift register.
//   CLOCK_50 : system clock
//   RESET    : asynchronous active-high reset
//   bus      : board-side bundle (raw step/run/din/flush in; shift strobe,
//              serial bit, BCD count, state and busy out)
// Manual steps come from the debounced step key, auto mode shifts every
// AUTO_DIV cycles, and a flush shifts WIDTH zeros while clearing the count.
module shift_reg_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = WIDTH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_DIV        = 25000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  shift_reg_ctrl_if.slave  bus
);

  localparam int unsigned PW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int unsigned FW = $clog2(WIDTH + 1);

  state_t        state_q, state_d;
  logic [1:0]    run_sync_q, din_sync_q, flush_sync_q;
  logic          flush_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          shift_en_q, shift_en_d;
  logic          shift_din_q, shift_din_d;
  logic          busy_q, busy_d;
  bcd2_t         cnt_q, cnt_d;

  logic run_s, din_s, flush_s, flush_evt, step_evt, step_level;

  key_debounce #(
    .STABLE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL   (1'b1)
  ) u_step_db (
    .clk     (CLOCK_50),
    .rst     (RESET),
    .key_n_i (bus.step_n),
    .level_o (step_level),
    .fall_o  (step_evt)
  );

  assign run_s     = run_sync_q[1];
  assign din_s     = din_sync_q[1];
  assign flush_s   = flush_sync_q[1];
  assign flush_evt = flush_s & ~flush_prev_q;

  // FSM state register
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (flush_evt) state_d = ST_FLUSH;
                else if (run_s) state_d = ST_AUTO;
      ST_AUTO:  if (flush_evt) state_d = ST_FLUSH;
                else if (!run_s) state_d = ST_IDLE;
      ST_FLUSH: if (fcnt_q == FW'(WIDTH)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. The first flush strobe is issued on the
  // entry edge, so fcnt_q counts strobes already sent and FLUSH lasts exactly
  // WIDTH cycles with shift_en high in every one of them.
  always_comb begin
    presc_d     = '0;
    fcnt_d      = '0;
    shift_en_d  = 1'b0;
    shift_din_d = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_evt) begin
          shift_en_d = 1'b1;
          fcnt_d     = FW'(1);
          cnt_d      = '0;
        end else if (!run_s && step_evt) begin
          shift_en_d  = 1'b1;
          shift_din_d = din_s;
          cnt_d       = bcd2_inc(cnt_q);
        end
      end
      ST_AUTO: begin
        if (flush_evt) begin
          shift_en_d = 1'b1;
          fcnt_d     = FW'(1);
          cnt_d      = '0;
        end else if (run_s) begin
          if (presc_q == PW'(AUTO_DIV - 1)) begin
            shift_en_d  = 1'b1;
            shift_din_d = din_s;
            cnt_d       = bcd2_inc(cnt_q);
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (fcnt_q != FW'(WIDTH)) begin
          shift_en_d = 1'b1;
          fcnt_d     = fcnt_q + FW'(1);
        end
      end
      default: ;
    endcase
    busy_d = (state_d == ST_FLUSH);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      run_sync_q   <= '0;
      din_sync_q   <= '0;
      flush_sync_q <= '0;
      flush_prev_q <= 1'b0;
      presc_q      <= '0;
      fcnt_q       <= '0;
      shift_en_q   <= 1'b0;
      shift_din_q  <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      run_sync_q   <= {run_sync_q[0], bus.run};
      din_sync_q   <= {din_sync_q[0], bus.din};
      flush_sync_q <= {flush_sync_q[0], bus.flush};
      flush_prev_q <= flush_s;
      presc_q      <= presc_d;
      fcnt_q       <= fcnt_d;
      shift_en_q   <= shift_en_d;
      shift_din_q  <= shift_din_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.shift_en  = shift_en_q;
  assign bus.shift_din = shift_din_q;
  assign bus.cnt_tens  = cnt_q.tens;
  assign bus.cnt_ones  = cnt_q.ones;
  assign bus.state     = state_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
module tb_shift_reg_ctrl;
  import shift_ctrl_pkg::*;

  localparam int unsigned W  = 10;
  localparam int unsigned DB = 4;
  localparam int unsigned AD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_reg_ctrl_if bus ();

  shift_reg_ctrl #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .AUTO_DIV        (AD)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  // Passive log of every observed shift strobe, sampled on the falling edge.
  typedef struct {
    int unsigned cyc;
    logic        din;
    logic        busy;
  } pulse_t;

  pulse_t      plog[$];
  int unsigned cyc = 0;
  logic [1:0]  prev_st = 2'd0;
  int unsigned auto_enter_cyc = 0;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    prev_st <= bus.state;
    if (bus.shift_en === 1'b1) plog.push_back('{cyc, bus.shift_din, bus.busy});
    if (bus.state === 2'd1 && prev_st !== 2'd1) auto_enter_cyc <= cyc;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt   = 0;   // reference shift count, 0..99

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_tens"}, 32'(bus.cnt_tens), 32'(m_cnt / 10));
    chk({tag, "_ones"}, 32'(bus.cnt_ones), 32'(m_cnt % 10));
  endtask

  // One manual press/release with a random hold time; expects one strobe.
  task automatic do_step(input logic d);
    int unsigned b;
    int unsigned np;
    b = plog.size();
    bus.din = d;
    cycles(3);
    bus.step_n = 1'b0;
    cycles(8 + $urandom_range(0, 4));
    bus.step_n = 1'b1;
    cycles(8 + $urandom_range(0, 4));
    np = plog.size() - b;
    chk("step_pulses", np, 1);
    if (np > 0) chk("step_din", 32'(plog[b].din), 32'(d));
    m_cnt = (m_cnt + 1) % 100;
    chk_cnt("step_cnt");
  endtask

  task automatic wait_busy(input string tag);
    int unsigned i;
    for (i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1) break;
    end
    chk(tag, 32'(bus.busy), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b, np, ones, notbusy, badgap, n_low;
    bus.step_n = 1'b1;
    bus.run    = 1'b0;
    bus.din    = 1'b0;
    bus.flush  = 1'b0;

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_shift_en",  32'(bus.shift_en),  0);
    chk("rst_shift_din", 32'(bus.shift_din), 0);
    chk("rst_state",     32'(bus.state),     0);
    chk("rst_busy",      32'(bus.busy),      0);
    chk("rst_tens",      32'(bus.cnt_tens),  0);
    chk("rst_ones",      32'(bus.cnt_ones),  0);
    cycles(2);
    rst = 1'b0;
    cycles(5);

    // Manual step with din=1, then a short glitch that must be rejected.
    do_step(1'b1);
    b = plog.size();
    bus.step_n = 1'b0;
    n_low = $urandom_range(1, 2);
    cycles(n_low);
    bus.step_n = 1'b1;
    cycles(15);
    chk("glitch_pulses", plog.size() - b, 0);
    chk_cnt("glitch_cnt");

    // Bring the count to 05 with random data.
    repeat (4) do_step(1'($urandom_range(0, 1)));
    chk_cnt("pre_flush_cnt");

    // Flush from 05 with din held high so zero data is meaningful.
    bus.din = 1'b1;
    cycles(3);
    b = plog.size();
    bus.flush = 1'b1;
    wait_busy("flush_busy");
    chk("flush_state", 32'(bus.state), 2);
    m_cnt = 0;
    chk_cnt("flush_cnt");
    cycles(20);
    bus.flush = 1'b0;
    np = plog.size() - b;
    ones = 0; notbusy = 0;
    for (int unsigned i = b; i < plog.size(); i++) begin
      if (plog[i].din !== 1'b0) ones++;
      if (plog[i].busy !== 1'b1) notbusy++;
    end
    chk("flush_pulses", np, W);
    chk("flush_ones", ones, 0);
    chk("flush_notbusy", notbusy, 0);
    if (np > 0) chk("flush_contig", plog[plog.size()-1].cyc - plog[b].cyc, W - 1);
    chk("flush_end_state", 32'(bus.state), 0);
    chk("flush_end_busy", 32'(bus.busy), 0);
    chk_cnt("flush_end_cnt");
    cycles(5);

    // Auto mode: run high for 40 cycles.
    bus.din = 1'($urandom_range(0, 1));
    cycles(3);
    b = plog.size();
    bus.run = 1'b1;
    cycles(20);
    chk("auto_state", 32'(bus.state), 1);
    cycles(20);
    bus.run = 1'b0;
    cycles(10);
    chk("auto_off_state", 32'(bus.state), 0);
    np = plog.size() - b;
    chk("auto_pulse_range", 32'(np >= 4 && np <= 5), 1);
    if (np > 0) chk("auto_first_lat", plog[b].cyc - auto_enter_cyc, AD);
    badgap = 0; ones = 0;
    for (int unsigned i = b; i < plog.size(); i++) begin
      if (i > b && plog[i].cyc - plog[i-1].cyc != AD) badgap++;
      if (plog[i].din !== bus.din) ones++;
    end
    chk("auto_gaps", badgap, 0);
    chk("auto_din", ones, 0);
    m_cnt = (m_cnt + int'(np)) % 100;
    chk_cnt("auto_cnt");
    b = plog.size();
    cycles(30);
    chk("auto_stopped", plog.size() - b, 0);

    // Flush edge and step event landing in the same cycle: 2-FF sync plus
    // DB samples puts the step event 4 cycles behind the flush event path.
    bus.din = 1'b1;
    cycles(3);
    b = plog.size();
    bus.step_n = 1'b0;
    cycles(4);
    bus.flush = 1'b1;
    cycles(25);
    bus.step_n = 1'b1;
    bus.flush  = 1'b0;
    cycles(15);
    ones = 0;
    for (int unsigned i = b; i < plog.size(); i++) if (plog[i].din !== 1'b0) ones++;
    chk("prio_pulses", plog.size() - b, W);
    chk("prio_ones", ones, 0);
    m_cnt = 0;
    chk_cnt("prio_cnt");
    chk("prio_state", 32'(bus.state), 0);

    // Reset during flush cycle 5; the partial flush must not resume.
    do_step(1'b1);
    bus.din = 1'b0;
    cycles(3);
    bus.flush = 1'b1;
    wait_busy("rstfl_busy");
    cycles(4);
    #2 rst = 1'b1;
    #1;
    chk("rstfl_state", 32'(bus.state), 0);
    chk("rstfl_shift_en", 32'(bus.shift_en), 0);
    chk("rstfl_busy0", 32'(bus.busy), 0);
    m_cnt = 0;
    chk_cnt("rstfl_cnt");
    bus.flush = 1'b0;
    cycles(2);
    rst = 1'b0;
    b = plog.size();
    cycles(20);
    chk("rstfl_no_resume", plog.size() - b, 0);

    // 100 manual steps: count reaches 99 and wraps to 00.
    for (int unsigned i = 0; i < 100; i++) begin
      do_step(1'($urandom_range(0, 1)));
      if (i == 98) begin
        chk("wrap99_tens", 32'(bus.cnt_tens), 9);
        chk("wrap99_ones", 32'(bus.cnt_ones), 9);
      end
      if (i == 99) begin
        chk("wrap00_tens", 32'(bus.cnt_tens), 0);
        chk("wrap00_ones", 32'(bus.cnt_ones), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
